// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared count width, period FSM states and the saturating counter step.
package freq_meter_pkg;
  localparam int CNT_W_DEF = 32;
  typedef enum logic {IDLE, ARMED} pstate_e;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction
endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: measured signal toward the meter, measurement results back to the monitor.
interface freq_meter_if #(parameter int CNT_W = freq_meter_pkg::CNT_W_DEF) ();
  logic             sig_in;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] freq_hz;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             period_valid;
  logic             no_signal;
  logic             overflow;
  modport master (output sig_in, input edge_cnt, freq_hz, period_cnt, meas_valid, period_valid, no_signal, overflow);
  modport slave  (input sig_in, output edge_cnt, freq_hz, period_cnt, meas_valid, period_valid, no_signal, overflow);
endinterface

// File: rtl/freq_meter_sync.sv
// sync_rise_det: two-flop synchronizer plus history flop, one-cycle pulse per synchronized rising edge.
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= '0;
    else s_q <= {s_q[1:0], d_i};
  assign rise_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter with scaled frequency, period measurement and signal-loss timeout.
module freq_meter import freq_meter_pkg::*; #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int GATE_DIV       = 1,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = CLK_FREQ
) (
  input logic         clk,
  input logic         rst,
  freq_meter_if.slave bus
);
  localparam int GATE_CYCLES = CLK_FREQ / GATE_DIV;
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [2*CNT_W-1:0] DIV_W = (2*CNT_W)'(GATE_DIV);
  logic rise, close, acc_sat, prod_sat, p_sat, tmo;
  logic [GW-1:0] g_q, g_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_sum, edge_cnt_q, freq_q, p_q, p_inc, period_cnt_q;
  logic [2*CNT_W-1:0] prod;
  logic meas_valid_q, period_valid_q, no_signal_q, overflow_q;
  pstate_e st_q;
  sync_rise_det u_sync (.clk(clk), .rst(rst), .d_i(bus.sig_in), .rise_o(rise));
  // A rise landing in the close cycle is folded into the closing window via acc_sum.
  always_comb begin
    close    = g_q == G_LAST;
    g_d      = close ? '0 : g_q + GW'(1);
    acc_sum  = rise ? CNT_W'(sat_inc(64'(acc_q), 64'(CNT_MAX))) : acc_q;
    acc_sat  = rise && acc_q == CNT_MAX;
    acc_d    = close ? '0 : acc_sum;
    prod     = (2*CNT_W)'(acc_sum) * DIV_W;
    prod_sat = close && prod[2*CNT_W-1:CNT_W] != '0;
    p_inc    = CNT_W'(sat_inc(64'(p_q), 64'(CNT_MAX)));
    tmo      = 64'(p_q) >= 64'(TIMEOUT_CYCLES);
    p_sat    = !rise && !no_signal_q && !tmo && p_q == CNT_MAX;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      g_q          <= '0;
      acc_q        <= '0;
      edge_cnt_q   <= '0;
      freq_q       <= '0;
      meas_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      g_q          <= g_d;
      acc_q        <= acc_d;
      meas_valid_q <= close;
      overflow_q   <= overflow_q | acc_sat | prod_sat | p_sat;
      if (close) begin
        edge_cnt_q <= acc_sum;
        freq_q     <= prod_sat ? CNT_MAX : prod[CNT_W-1:0];
      end
    end
  // p also runs while IDLE so a signal that never toggles after reset still times out.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q           <= IDLE;
      p_q            <= '0;
      period_cnt_q   <= '0;
      period_valid_q <= 1'b0;
      no_signal_q    <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (rise) begin
        if (st_q == ARMED) begin
          period_cnt_q   <= p_q;
          period_valid_q <= 1'b1;
        end
        st_q        <= ARMED;
        p_q         <= CNT_W'(1);
        no_signal_q <= 1'b0;
      end else if (!no_signal_q) begin
        if (tmo) begin
          no_signal_q <= 1'b1;
          st_q        <= IDLE;
        end else p_q <= p_inc;
      end
    end
  assign bus.edge_cnt     = edge_cnt_q;
  assign bus.freq_hz      = freq_q;
  assign bus.meas_valid   = meas_valid_q;
  assign bus.period_cnt   = period_cnt_q;
  assign bus.period_valid = period_valid_q;
  assign bus.no_signal    = no_signal_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: event-level reference model plus table and directed checks on 32-bit and 8-bit meters.
module tb_freq_meter;
  localparam int CF = 1000, GD = 10, TO = 50, GC = CF / GD;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0;
  freq_meter_if #(.CNT_W(32)) bus ();
  freq_meter_if #(.CNT_W(8)) bus8 ();
  freq_meter #(.CLK_FREQ(CF), .GATE_DIV(GD), .CNT_W(32), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  freq_meter #(.CLK_FREQ(CF), .GATE_DIV(GD), .CNT_W(8), .TIMEOUT_CYCLES(TO)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset release, sampled input history, and the edge indices where rises are registered.
  int n = 0, e_ec = 0, e_pc = 0, pv_cnt = 0, first_pc = -1, first_mv = -1;
  longint e_fq = 0;
  bit e_mv, e_pv, e_ns;
  bit smp[$];
  int rises[$];
  function automatic bit sg(int k);
    return (k >= 1) ? smp[k-1] : 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n = 0; smp.delete(); rises.delete();
      e_ec = 0; e_fq = 0; e_pc = 0; pv_cnt = 0; first_pc = -1; first_mv = -1;
    end else begin
      int c;
      bit r;
      n++;
      smp.push_back(bus.sig_in);
      r = sg(n - 2) && !sg(n - 3);
      e_pv = 1'b0;
      if (r) begin
        if (rises.size() > 0 && n - rises[$] <= TO) begin
          e_pv = 1'b1;
          e_pc = n - rises[$];
        end
        rises.push_back(n);
      end
      e_ns = (n - (rises.size() > 0 ? rises[$] : 1)) >= TO;
      e_mv = (n % GC) == 0;
      if (e_mv) begin
        c = 0;
        foreach (rises[i]) if (rises[i] > n - GC) c++;
        e_ec = c;
        e_fq = longint'(c) * GD;
      end
      #1;
      chk("m_edge_cnt", bus.edge_cnt, e_ec);
      chk("m_freq_hz", bus.freq_hz, e_fq);
      chk("m_meas_valid", bus.meas_valid, e_mv);
      chk("m_period_valid", bus.period_valid, e_pv);
      chk("m_period_cnt", bus.period_cnt, e_pc);
      chk("m_no_signal", bus.no_signal, e_ns);
      chk("m_overflow", bus.overflow, 0);
      pv_cnt += bus.period_valid;
      if (bus.period_valid && first_pc < 0) first_pc = bus.period_cnt;
      if (bus.meas_valid && first_mv < 0) first_mv = n;
    end
  end

  task automatic do_reset;
    rst = 1'b1; bus.sig_in = 1'b0; bus8.sig_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wave(input int per, input int hi, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      bus.sig_in = (i % per) < hi;
      @(negedge clk);
    end
  endtask

  task automatic wait_n(input int k);
    for (int b = 0; b < 5000 && n < k; b++) @(negedge clk);
    if (n < k) chk("wait_budget", n, k);
  endtask

  typedef struct {int per; int hi; int ec; int fq; int pc;} vec_t;
  vec_t tbl[4];
  int per, hi, last;

  initial begin
    tbl[0] = '{10, 5, 10, 100, 10};
    tbl[1] = '{20, 10, 5, 50, 20};
    tbl[2] = '{4, 2, 25, 250, 4};
    tbl[3] = '{25, 12, 4, 40, 25};
    bus.sig_in = 1'b0; bus8.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst edge_cnt", bus.edge_cnt, 0);
    chk("rst freq_hz", bus.freq_hz, 0);
    chk("rst meas_valid", bus.meas_valid, 0);
    chk("rst period_cnt", bus.period_cnt, 0);
    chk("rst period_valid", bus.period_valid, 0);
    chk("rst no_signal", bus.no_signal, 0);
    chk("rst overflow", bus.overflow, 0);
    foreach (tbl[i]) begin
      do_reset;
      wave(tbl[i].per, tbl[i].hi, 200);
      chk("tbl edge_cnt", bus.edge_cnt, tbl[i].ec);
      chk("tbl freq_hz", bus.freq_hz, tbl[i].fq);
      chk("tbl period_cnt", bus.period_cnt, tbl[i].pc);
      chk("tbl overflow", bus.overflow, 0);
    end
    for (int k = 0; k < 6; k++) begin
      per = $urandom_range(4, 40);
      hi = $urandom_range(2, per - 2);
      do_reset;
      wave(per, hi, 160);
      chk("rand period_cnt", bus.period_cnt, per);
    end
    do_reset;
    for (int k = 0; k < 80; k++) begin
      bus.sig_in = 1'($urandom_range(0, 1));
      repeat (k % 20 == 19 ? 60 : $urandom_range(1, 8)) @(negedge clk);
    end
    do_reset;
    wait_n(2 * GC);
    chk("t2 edge_cnt", bus.edge_cnt, 0);
    chk("t2 no_signal", bus.no_signal, 1);
    chk("t2 no period_valid", pv_cnt, 0);
    wave(20, 10, 100);
    chk("t2 first period", first_pc, 20);
    chk("t2 signal back", bus.no_signal, 0);
    do_reset;
    wait_n(GC - 3);
    bus.sig_in = 1'b1;
    wait_n(GC);
    chk("t3 meas_valid", bus.meas_valid, 1);
    chk("t3 close-cycle edge", bus.edge_cnt, 1);
    bus.sig_in = 1'b0;
    wait_n(2 * GC);
    chk("t3 next gate", bus.edge_cnt, 0);
    do_reset;
    wave(10, 5, 150);
    chk("t4 before reset", bus.edge_cnt, 10);
    rst = 1'b1;
    #1;
    chk("t4 async edge_cnt", bus.edge_cnt, 0);
    chk("t4 async freq_hz", bus.freq_hz, 0);
    chk("t4 async period_cnt", bus.period_cnt, 0);
    chk("t4 async meas_valid", bus.meas_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    wave(10, 5, 120);
    chk("t4 first meas after reset", first_mv, GC);
    do_reset;
    for (int i = 0; i < 200; i++) begin
      bus8.sig_in = (i % 10 < 5) && (i % 2 == 0);
      bus.sig_in = bus8.sig_in;
      @(negedge clk);
    end
    chk("t5 edge_cnt8", bus8.edge_cnt, 30);
    chk("t5 freq_hz8", bus8.freq_hz, 255);
    chk("t5 overflow8", bus8.overflow, 1);
    chk("t5 freq_hz32", bus.freq_hz, 300);
    bus8.sig_in = 1'b0; bus.sig_in = 1'b0;
    wait_n(3 * GC);
    chk("t5 edge_cnt8 idle", bus8.edge_cnt, 0);
    chk("t5 overflow8 sticky", bus8.overflow, 1);
    do_reset;
    wave(4, 2, 120);
    bus.sig_in = 1'b1;
    wait_n(n + 6);
    last = rises[$];
    wait_n(last + TO - 1);
    chk("t6 no_signal early", bus.no_signal, 0);
    wait_n(last + TO);
    chk("t6 no_signal on time", bus.no_signal, 1);
    chk("t6 period held", bus.period_cnt, 4);
    wait_n(last + 2 * TO);
    chk("t6 no_signal stays", bus.no_signal, 1);
    chk("t6 period still held", bus.period_cnt, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency and period of an external square wave, such as the output of a frequency divider or a signal from an off-chip pin.
- The input is treated as asynchronous to clk. It is synchronized and its rising edges are counted over a fixed gate window derived from the system clock.
- Reports edge count per gate, scaled frequency in Hz, and the period of the last cycle in clk ticks. Intended for self-test of divider outputs and for board-level signal monitoring.

Parameters:
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- GATE_DIV, 1: gate window length is GATE_CYCLES = CLK_FREQ / GATE_DIV clk cycles. Frequency resolution is GATE_DIV Hz.
- CNT_W, 32: width of all count and result registers.
- TIMEOUT_CYCLES, CLK_FREQ: clk cycles with no rising edge before no_signal asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sig_in  in  1  measured signal, asynchronous to clk.
- edge_cnt  out  CNT_W  rising edges counted in the last completed gate.
- freq_hz  out  CNT_W  edge_cnt * GATE_DIV, saturated.
- meas_valid  out  1  one-cycle pulse when edge_cnt and freq_hz update.
- period_cnt  out  CNT_W  clk cycles between the last two rising edges.
- period_valid  out  1  one-cycle pulse when period_cnt updates.
- no_signal  out  1  high when no rising edge has been seen for TIMEOUT_CYCLES.
- overflow  out  1  sticky; set on any count or product saturation, cleared only by rst.

Behaviour:
- Reset: all outputs 0, all internal counters 0, period FSM in IDLE. Reset takes effect immediately at any point, including mid-gate; the partial gate is discarded.
- Synchronizer: two flops (s1, s2) plus a history flop s3. rise = s2 & ~s3.
  - rise asserts on the 3rd clk edge after sig_in goes high, if setup is met.
  - One rise pulse per input rising edge. Input high or low times shorter than 2 clk cycles are not guaranteed to be counted.
- Gate counter g runs 0 .. GATE_CYCLES-1 and wraps; it starts at 0 after reset.
- Edge accumulator acc increments on rise and saturates at all-ones.
- Gate-close cycle (g == GATE_CYCLES-1):
  - edge_cnt <= acc + rise (saturating). A rise in the close cycle belongs to the closing window.
  - freq_hz <= (acc + rise) * GATE_DIV. The product is computed at 2*CNT_W bits; if it exceeds CNT_W bits, freq_hz = all-ones and overflow is set.
  - acc <= 0. meas_valid = 1 in the following cycle, coincident with the new outputs.
- First meas_valid occurs GATE_CYCLES cycles after reset release. edge_cnt and freq_hz hold their values between gate closes.
- Period FSM, states IDLE, ARMED:
  - IDLE: on rise, p <= 1 and go to ARMED. Nothing is reported.
  - ARMED, every cycle without rise: p <= p+1, saturating; if p saturates, set overflow.
  - ARMED, on rise: period_cnt <= p, period_valid = 1 next cycle, p <= 1, stay ARMED.
  - ARMED, when p reaches TIMEOUT_CYCLES with no rise: no_signal <= 1 and go to IDLE. period_cnt holds its last value.
  - no_signal clears on the next rise, in the same cycle the FSM moves IDLE to ARMED.
- Example: a square wave with a period of N clk produces period_cnt = N.
- A constant sig_in (0 or 1) gives edge_cnt = 0 every gate and no_signal = 1 after the timeout.
- Simultaneous rise and gate close: the edge is counted in the closing gate. The period path is unaffected.
- meas_valid and period_valid are independent and may assert in the same cycle.

Decomposition:
- Package freq_meter_pkg: CNT_W default and a saturating-increment function shared by the acc and p counters.
- Sub-module sync_rise_det: 2-flop synchronizer plus edge flop, outputting rise. It is reused for other asynchronous inputs in the design.
- Gate counter, accumulator, scaler and period FSM stay in the top level.

Test Plan:
- Bench parameters: CLK_FREQ=1000, GATE_DIV=10 (GATE_CYCLES=100), TIMEOUT_CYCLES=50.
- Test 1: sig_in square wave with a 10-clk period, starting after reset -> each meas_valid after the first gate shows edge_cnt=10, freq_hz=100; period_valid pulses every 10 clk with period_cnt=10; overflow=0.
- Test 2: sig_in held 0 for 200 clk after reset -> edge_cnt=0 at clk 100 and 200; no_signal=1 (the FSM never left IDLE; no_signal asserts by timeout behaviour); no period_valid. Then a 20-clk-period wave is applied -> no_signal clears on the first rise; the first period_valid shows 20.
- Test 3: sig_in rising edge placed so rise coincides with g=99 -> that edge is counted in the closing gate's edge_cnt, and the next gate's acc starts at 0.
- Test 4: rst asserted for 1 clk at g=50 while edges are being counted -> outputs go 0 immediately; the next meas_valid comes 100 clk after release, with only post-reset edges counted.
- Test 5: CNT_W=8, GATE_DIV=10, 30 edges per gate -> the product 300 saturates: freq_hz=255, edge_cnt=30, overflow=1 and stays set.
- Test 6: a 4-clk-period wave then stopped high -> period_cnt=4 repeatedly; no_signal=1 exactly 50 clk after the last rise; period_cnt holds at 4.
